// File: rtl/triplet_pkg.sv
// Shared types and defaults for the triplet loader: FSM states and
// default operand/counter widths.
package triplet_pkg;
    localparam int WIDTH_DEF = 3;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_C   = 2'd2,
        S_OUT = 2'd3
    } state_t;
endpackage

// File: rtl/triplet_loader_if.sv
// Upstream word stream, downstream triplet handshake and delivered-triplet count,
// bundled for the loader (slave) and its environment (master).
interface triplet_loader_if
    import triplet_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and payload is held while valid is high.
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             flush;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic             abc_valid;
    logic             abc_ready;
    logic [CNT_W-1:0] trip_cnt;

    modport slave (
        input  din, din_valid, flush, abc_ready,
        output din_ready, A, B, C, abc_valid, trip_cnt
    );

    modport master (
        output din, din_valid, flush, abc_ready,
        input  din_ready, A, B, C, abc_valid, trip_cnt
    );
endinterface

// File: rtl/wrap_counter.sv
// Free-running enable counter that wraps silently modulo 2^W.
module wrap_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/triplet_loader.sv
// Collects three upstream words into A, B, C and presents them as one triplet
// to the downstream comparator stage; counts delivered triplets.
module triplet_loader
    import triplet_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    triplet_loader_if.slave         bus,
    output state_t                  state_dbg
);
    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] c_q;
    logic             accept;
    logic             handshake;

    // rst is folded in so ready drops the instant reset asserts, not at the next edge.
    assign bus.din_ready = (state != S_OUT) && !bus.flush && !rst;
    assign accept        = bus.din_valid && bus.din_ready;
    assign bus.abc_valid = (state == S_OUT);
    assign handshake     = bus.abc_valid && bus.abc_ready;
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.C         = c_q;
    assign state_dbg     = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_A;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_A:     if (accept) state_nxt = S_B;
            S_B:     if (accept) state_nxt = S_C;
            S_C:     if (accept) state_nxt = S_OUT;
            S_OUT:   if (handshake) state_nxt = S_A;
            default: state_nxt = S_A;
        endcase
        if (bus.flush) begin
            state_nxt = S_A;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else if (bus.flush) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else if (accept) begin
            case (state)
                S_A:     a_q <= bus.din;
                S_B:     b_q <= bus.din;
                S_C:     c_q <= bus.din;
                default: ;
            endcase
        end
    end

    // A flush landing on a completed handshake still counts that triplet.
    wrap_counter #(.W(CNT_W)) u_trip_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (handshake),
        .count (bus.trip_cnt)
    );
endmodule
